// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundles the fetch port, the load/store data port and the
// unified memory port of the memory arbiter.
//
// Signal groups (directions seen from the arbiter, modport slave):
//   fetch port : if_req, if_addr in; if_gnt, if_rvalid, if_rdata, if_err out
//   data port  : d_req, d_we, d_addr, d_wdata in; d_gnt, d_rvalid, d_rdata,
//                d_err out
//   memory     : mem_read, mem_write, mem_endereco, mem_write_data out;
//                mem_read_data in (combinational read from the memory)
// The master modport is the environment view: the requesters plus the memory.
interface mem_arbiter_if;
  // fetch port
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        if_err;
  // data port
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        d_err;
  // unified memory
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_endereco;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata, if_err,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_read, mem_write, mem_endereco, mem_write_data,
    input  mem_read_data
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_read, mem_write, mem_endereco, mem_write_data,
    output mem_read_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one byte-addressed unified memory between the
// instruction-fetch port and the load/store data port.
//
// One access is granted per cycle (combinational gnt). Data beats fetch,
// except that a fetch which has lost MAX_WAIT consecutive cycles is forced to
// win. The memory's combinational read word is captured at the grant edge and
// returned to the winner with a one-cycle rvalid pulse. Accesses whose 8-byte
// window runs past the end of memory are granted but never reach the memory;
// they answer with err = 1 and rdata = 0.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : mem_arbiter_if.slave (fetch port, data port, memory port)
module mem_arbiter #(
  parameter int MEM_BYTES = 2048,
  parameter int MAX_WAIT  = 3
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int          CW      = (MAX_WAIT < 3) ? 2 : $clog2(MAX_WAIT + 1);
  localparam logic [63:0] LAST_OK = 64'(MEM_BYTES - 8);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

  // registered state
  logic [CW-1:0] starve_q,    starve_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic [63:0]   if_rdata_q,  if_rdata_d;
  logic          if_err_q,    if_err_d;
  logic          d_rvalid_q,  d_rvalid_d;
  logic [63:0]   d_rdata_q,   d_rdata_d;
  logic          d_err_q,     d_err_d;

  logic if_win, d_win;
  logic if_oor, d_oor;

  // Full 64-bit unsigned compare: any address whose last byte lies past the
  // end of memory is an error, including huge wrapped values.
  assign if_oor = (bus.if_addr > LAST_OK);
  assign d_oor  = (bus.d_addr  > LAST_OK);

  // Grant and memory drive. Reset suppresses every grant so nothing can be
  // committed while reset is held.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    if_win             = 1'b0;
    d_win              = 1'b0;
    bus.mem_read       = 1'b0;
    bus.mem_write      = 1'b0;
    bus.mem_endereco   = '0;
    bus.mem_write_data = '0;

    if (!reset) begin
      if_win = bus.if_req && (!bus.d_req || starve_q == CNT_MAX);
      d_win  = bus.d_req && !if_win;
    end

    if (if_win) begin
      bus.mem_endereco = bus.if_addr;
      bus.mem_read     = !if_oor;
    end else if (d_win) begin
      bus.mem_endereco = bus.d_addr;
      if (bus.d_we) begin
        bus.mem_write      = !d_oor;
        bus.mem_write_data = bus.d_wdata;
      end else begin
        bus.mem_read = !d_oor;
      end
    end
  end

  assign bus.if_gnt = if_win;
  assign bus.d_gnt  = d_win;

  // Response capture and starvation counter.
  always_comb begin
    if_rvalid_d = if_win;
    if_err_d    = if_err_q;
    if_rdata_d  = if_rdata_q;
    d_rvalid_d  = d_win;
    d_err_d     = d_err_q;
    d_rdata_d   = d_rdata_q;
    starve_d    = starve_q;

    if (if_win) begin
      if_err_d   = if_oor;
      if_rdata_d = if_oor ? '0 : bus.mem_read_data;
    end
    if (d_win) begin
      d_err_d   = d_oor;
      // a store ack carries no data
      d_rdata_d = (d_oor || bus.d_we) ? '0 : bus.mem_read_data;
    end

    if (!bus.if_req || if_win)
      starve_d = '0;
    else if (d_win && starve_q != CNT_MAX)
      starve_d = starve_q + CW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      if_err_q    <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      d_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values of the combinational next-state signals.
      starve_q    <= starve_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      if_err_q    <= if_err_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
    end
  end

  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- directed test of mem_arbiter with a behavioural 2 KiB
// big-endian memory attached to the memory port.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mem_arbiter_if bus ();

  mem_arbiter #(.MEM_BYTES(2048), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural memory: combinational big-endian read, write on rising edge.
  logic [7:0] mem [0:2047];

  always_comb begin
    bus.mem_read_data = '0;
    if (bus.mem_endereco <= 64'd2040)
      for (int i = 0; i < 8; i++)
        bus.mem_read_data = {bus.mem_read_data[55:0],
                             mem[int'(bus.mem_endereco[10:0]) + i]};
  end

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_endereco <= 64'd2040)
      for (int i = 0; i < 8; i++)
        mem[int'(bus.mem_endereco[10:0]) + i] <= bus.mem_write_data[63-8*i -: 8];
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_d(input logic req, input logic we,
                         input logic [63:0] addr, input logic [63:0] wdata);
    bus.d_req   = req;
    bus.d_we    = we;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
  endtask

  task automatic drive_if(input logic req, input logic [63:0] addr);
    bus.if_req  = req;
    bus.if_addr = addr;
  endtask

  // Expected grant pattern under contention: D,D,D,F,D,D
  logic [5:0]  exp_fgnt = 6'b001000;  // bit i-1 = fetch wins in cycle i
  int          exp_cnt [6] = '{1, 2, 3, 0, 1, 2};

  initial begin
    // memory preload: bytes 0..7 = 00..00,08; 1024.. = A0..A7; 2040.. = F0..F7
    for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
    #0;
    mem[7] <= 8'h08;
    for (int i = 0; i < 8; i++) begin
      mem[1024 + i] <= 8'hA0 + 8'(i);
      mem[2040 + i] <= 8'hF0 + 8'(i);
    end

    reset = 1'b1;
    drive_if(1'b0, 64'd0);
    drive_d(1'b1, 1'b0, 64'd0, 64'd0);

    // ---- reset state: requests present, nothing granted
    @(negedge clk); #1;
    check("rst_d_gnt",     64'(bus.d_gnt),     64'd0);
    check("rst_mem_read",  64'(bus.mem_read),  64'd0);
    check("rst_d_rvalid",  64'(bus.d_rvalid),  64'd0);
    check("rst_d_rdata",   bus.d_rdata,        64'd0);
    check("rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    check("rst_cnt",       64'(dut.starve_q),  64'd0);
    drive_d(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // ---- load from address 0
    @(negedge clk);
    drive_d(1'b1, 1'b0, 64'd0, 64'd0);
    #1;
    check("ld0_d_gnt",    64'(bus.d_gnt),    64'd1);
    check("ld0_if_gnt",   64'(bus.if_gnt),   64'd0);
    check("ld0_mem_read", 64'(bus.mem_read), 64'd1);
    @(posedge clk); #1;
    check("ld0_rvalid", 64'(bus.d_rvalid), 64'd1);
    check("ld0_rdata",  bus.d_rdata,       64'h8);
    check("ld0_err",    64'(bus.d_err),    64'd0);

    // ---- store at 24, then load it back
    @(negedge clk);
    drive_d(1'b1, 1'b1, 64'd24, 64'h0102030405060708);
    #1;
    check("st_mem_write", 64'(bus.mem_write),  64'd1);
    check("st_mem_read",  64'(bus.mem_read),   64'd0);
    check("st_wdata",     bus.mem_write_data,  64'h0102030405060708);
    check("st_addr",      bus.mem_endereco,    64'd24);
    @(posedge clk); #1;
    check("st_ack_rvalid", 64'(bus.d_rvalid), 64'd1);
    check("st_ack_rdata",  bus.d_rdata,       64'd0);
    check("st_mem24",      64'(mem[24]),      64'h01);
    check("st_mem31",      64'(mem[31]),      64'h08);
    @(negedge clk);
    drive_d(1'b1, 1'b0, 64'd24, 64'd0);
    @(posedge clk); #1;
    check("ld24_rdata", bus.d_rdata, 64'h0102030405060708);

    // ---- out of range 2041, then last legal address 2040
    @(negedge clk);
    drive_d(1'b1, 1'b0, 64'd2041, 64'd0);
    #1;
    check("oor_d_gnt",    64'(bus.d_gnt),    64'd1);
    check("oor_mem_read", 64'(bus.mem_read), 64'd0);
    @(posedge clk); #1;
    check("oor_rvalid", 64'(bus.d_rvalid), 64'd1);
    check("oor_err",    64'(bus.d_err),    64'd1);
    check("oor_rdata",  bus.d_rdata,       64'd0);
    @(negedge clk);
    drive_d(1'b1, 1'b0, 64'd2040, 64'd0);
    #1;
    check("edge_mem_read", 64'(bus.mem_read), 64'd1);
    @(posedge clk); #1;
    check("edge_err",   64'(bus.d_err), 64'd0);
    check("edge_rdata", bus.d_rdata,    64'hF0F1F2F3F4F5F6F7);
    @(negedge clk);
    drive_d(1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk); #1;
    check("idle_d_rvalid", 64'(bus.d_rvalid), 64'd0);

    // ---- fetch at 1024, no data traffic
    @(negedge clk);
    drive_if(1'b1, 64'd1024);
    #1;
    check("f_if_gnt",   64'(bus.if_gnt),   64'd1);
    check("f_mem_read", 64'(bus.mem_read), 64'd1);
    check("f_addr",     bus.mem_endereco,  64'd1024);
    @(posedge clk); #1;
    check("f_rvalid",   64'(bus.if_rvalid), 64'd1);
    check("f_rdata",    bus.if_rdata,       64'hA0A1A2A3A4A5A6A7);
    check("f_err",      64'(bus.if_err),    64'd0);
    check("f_d_rvalid", 64'(bus.d_rvalid),  64'd0);
    @(negedge clk);
    drive_if(1'b0, 64'd0);
    @(posedge clk);

    // ---- contention for 6 cycles: grants D,D,D,F,D,D
    @(negedge clk);
    drive_if(1'b1, 64'd1024);
    drive_d(1'b1, 1'b0, 64'd0, 64'd0);
    for (int c = 0; c < 6; c++) begin
      #1;
      check($sformatf("cont%0d_if_gnt", c + 1), 64'(bus.if_gnt), 64'(exp_fgnt[c]));
      check($sformatf("cont%0d_d_gnt", c + 1),  64'(bus.d_gnt),  64'(!exp_fgnt[c]));
      @(posedge clk); #1;
      check($sformatf("cont%0d_cnt", c + 1), 64'(dut.starve_q), 64'(exp_cnt[c]));
      check($sformatf("cont%0d_if_rvalid", c + 1), 64'(bus.if_rvalid), 64'(exp_fgnt[c]));
      @(negedge clk);
    end
    drive_if(1'b0, 64'd0);
    drive_d(1'b0, 1'b0, 64'd0, 64'd0);
    @(posedge clk);

    // ---- async reset mid-cycle after a grant; earlier store survives
    @(negedge clk);
    drive_d(1'b1, 1'b1, 64'd100, 64'hDEADBEEFCAFEF00D);
    @(negedge clk);
    drive_d(1'b1, 1'b0, 64'd2041, 64'd0);  // erroring load, fetch loses
    drive_if(1'b1, 64'd1024);
    @(posedge clk); #1;
    check("pre_rst_err", 64'(bus.d_err),    64'd1);
    check("pre_rst_cnt", 64'(dut.starve_q), 64'd1);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_rvalid", 64'(bus.d_rvalid), 64'd0);
    check("mid_rst_err",    64'(bus.d_err),    64'd0);
    check("mid_rst_rdata",  bus.d_rdata,       64'd0);
    check("mid_rst_cnt",    64'(dut.starve_q), 64'd0);
    check("mid_rst_gnt",    64'({bus.if_gnt, bus.d_gnt}), 64'd0);
    drive_if(1'b0, 64'd0);
    drive_d(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_d_rvalid",  64'(bus.d_rvalid),  64'd0);
    check("post_rst_if_rvalid", 64'(bus.if_rvalid), 64'd0);
    @(negedge clk);
    drive_d(1'b1, 1'b0, 64'd100, 64'd0);
    @(posedge clk); #1;
    check("post_rst_ld100", bus.d_rdata, 64'hDEADBEEFCAFEF00D);
    @(negedge clk);
    drive_d(1'b0, 1'b0, 64'd0, 64'd0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
